dsc_slice_sched: RTL and testbench

DSC_SLICE_SCHED -- requirements
Module: dsc_slice_sched

---
 rtl/dsc_pkg.sv | 16 +
 rtl/dsc_slice_sched.sv | 189 ++++++++++++++++++
 tb/tb_dsc_slice_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dsc_pkg.sv
// Shared types and constants for the DSC slice scheduler.
// The FSM state enum lives here so the scheduler and any tooling agree on it.
package dsc_pkg;

  localparam int DSC_DIM_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHK_W = 3'd1,
    CHK_H = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4,
    ERR   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/dsc_slice_sched.sv
// DSC slice scheduler: validates the picture/slice tiling by repeated subtraction,
// then issues slice commands in raster order with a cap on outstanding slices.
module dsc_slice_sched
  import dsc_pkg::*;
#(
  parameter int DIM_W   = DSC_DIM_W,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] pic_w,
  input  logic [DIM_W-1:0] pic_h,
  input  logic [DIM_W-1:0] slice_w,
  input  logic [DIM_W-1:0] slice_h,
  output logic             busy,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [DIM_W-1:0] cmd_x,
  output logic [DIM_W-1:0] cmd_y,
  output logic [DIM_W-1:0] cmd_idx,
  output logic             cmd_last,
  input  logic             slice_done,
  output logic             frame_done,
  output logic             cfg_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  sched_state_t     state_reg, state_next;
  logic [DIM_W-1:0] pic_w_reg, pic_w_next;
  logic [DIM_W-1:0] pic_h_reg, pic_h_next;
  logic [DIM_W-1:0] slice_w_reg, slice_w_next;
  logic [DIM_W-1:0] slice_h_reg, slice_h_next;
  logic [DIM_W-1:0] rem_reg, rem_next;
  logic [DIM_W-1:0] cols_reg, cols_next;
  logic [DIM_W-1:0] rows_reg, rows_next;
  logic [DIM_W-1:0] x_reg, x_next;
  logic [DIM_W-1:0] y_reg, y_next;
  logic [DIM_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;

  logic issuing;
  logic x_end;
  logic y_end;
  logic handshake;
  logic done_eff;

  assign issuing   = (state_reg == ISSUE);
  assign x_end     = ((x_reg + slice_w_reg) == pic_w_reg);
  assign y_end     = ((y_reg + slice_h_reg) == pic_h_reg);
  assign cmd_valid = issuing && (out_cnt_reg < MAX_CNT);
  assign handshake = cmd_valid && cmd_ready;
  // A completion with nothing outstanding is a stray pulse and must not underflow.
  assign done_eff  = slice_done && (out_cnt_reg != '0);

  assign busy       = (state_reg != IDLE);
  assign cfg_err    = (state_reg == ERR);
  assign frame_done = (state_reg == DRAIN) && (out_cnt_reg == '0);
  assign cmd_last   = issuing && x_end && y_end;
  assign cmd_x      = issuing ? x_reg   : '0;
  assign cmd_y      = issuing ? y_reg   : '0;
  assign cmd_idx    = issuing ? idx_reg : '0;

  always_comb begin
    state_next   = state_reg;
    pic_w_next   = pic_w_reg;
    pic_h_next   = pic_h_reg;
    slice_w_next = slice_w_reg;
    slice_h_next = slice_h_reg;
    rem_next     = rem_reg;
    cols_next    = cols_reg;
    rows_next    = rows_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    idx_next     = idx_reg;
    out_cnt_next = out_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          pic_w_next   = pic_w;
          pic_h_next   = pic_h;
          slice_w_next = slice_w;
          slice_h_next = slice_h;
          if ((pic_w == '0) || (pic_h == '0) || (slice_w == '0) || (slice_h == '0)) begin
            state_next = ERR;
          end else begin
            state_next = CHK_W;
            rem_next   = pic_w;
            cols_next  = '0;
          end
        end
      end
      // One subtraction per cycle stands in for a divider; a non-zero remainder
      // smaller than the slice means the picture does not tile exactly.
      CHK_W: begin
        if (rem_reg >= slice_w_reg) begin
          rem_next  = rem_reg - slice_w_reg;
          cols_next = cols_reg + DIM_W'(1);
          if (rem_reg == slice_w_reg) begin
            state_next = CHK_H;
            rem_next   = pic_h_reg;
            rows_next  = '0;
          end
        end else begin
          state_next = ERR;
        end
      end
      CHK_H: begin
        if (rem_reg >= slice_h_reg) begin
          rem_next  = rem_reg - slice_h_reg;
          rows_next = rows_reg + DIM_W'(1);
          if (rem_reg == slice_h_reg) begin
            state_next = ISSUE;
            x_next     = '0;
            y_next     = '0;
            idx_next   = '0;
          end
        end else begin
          state_next = ERR;
        end
      end
      ISSUE: begin
        if (handshake) begin
          idx_next = idx_reg + DIM_W'(1);
          if (x_end) begin
            x_next = '0;
            y_next = y_reg + slice_h_reg;
          end else begin
            x_next = x_reg + slice_w_reg;
          end
          if (cmd_last) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_cnt_reg == '0) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (handshake && !done_eff) begin
      out_cnt_next = out_cnt_reg + CNT_W'(1);
    end else if (done_eff && !handshake) begin
      out_cnt_next = out_cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pic_w_reg   <= '0;
      pic_h_reg   <= '0;
      slice_w_reg <= '0;
      slice_h_reg <= '0;
      rem_reg     <= '0;
      cols_reg    <= '0;
      rows_reg    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      idx_reg     <= '0;
      out_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pic_w_reg   <= pic_w_next;
      pic_h_reg   <= pic_h_next;
      slice_w_reg <= slice_w_next;
      slice_h_reg <= slice_h_next;
      rem_reg     <= rem_next;
      cols_reg    <= cols_next;
      rows_reg    <= rows_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      idx_reg     <= idx_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

endmodule

// File: tb/tb_dsc_slice_sched.sv
// Randomized bench for dsc_slice_sched; expected commands and timing come from
// division-based tiling arithmetic and an outstanding-slice count kept here.
module tb_dsc_slice_sched;

  localparam int DIM_W   = 16;
  localparam int MAX_OUT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [DIM_W-1:0] pic_w, pic_h, slice_w, slice_h;
  logic             busy, cmd_valid, cmd_ready, cmd_last;
  logic [DIM_W-1:0] cmd_x, cmd_y, cmd_idx;
  logic             slice_done, frame_done, cfg_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dsc_slice_sched #(.DIM_W(DIM_W), .MAX_OUT(MAX_OUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pic_w      (pic_w),
    .pic_h      (pic_h),
    .slice_w    (slice_w),
    .slice_h    (slice_h),
    .busy       (busy),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_idx    (cmd_idx),
    .cmd_last   (cmd_last),
    .slice_done (slice_done),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_x"}, cmd_x, 0);
    chk({tag, "_y"}, cmd_y, 0);
    chk({tag, "_idx"}, cmd_idx, 0);
    chk({tag, "_last"}, cmd_last, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_cfgerr"}, cfg_err, 0);
  endtask

  // done_pct < 0 selects "slice_done exactly 3 cycles after each handshake".
  task automatic run_frame(input int pw, input int ph, input int sw, input int sh,
                           input int ready_pct, input int done_pct, input int withhold,
                           input bit abort_drain);
    int qx[$], qy[$], qi[$];
    int sched[$];
    int cols, rows, err_cycle, issue_cycle, outstanding, k;
    bit legal, draining, finished, exp_valid, exp_fd, in_issue, rdy, sd, hs;

    cols = 0; rows = 0; err_cycle = 0; issue_cycle = 0;
    if (pw == 0 || ph == 0 || sw == 0 || sh == 0) begin
      legal = 0; err_cycle = 1;
    end else if (pw % sw != 0) begin
      legal = 0; err_cycle = pw / sw + 2;
    end else if (ph % sh != 0) begin
      legal = 0; err_cycle = pw / sw + ph / sh + 2;
    end else begin
      legal = 1; cols = pw / sw; rows = ph / sh; issue_cycle = cols + rows + 1;
      for (int j = 0; j < rows; j++)
        for (int i = 0; i < cols; i++) begin
          qx.push_back(i * sw); qy.push_back(j * sh); qi.push_back(j * cols + i);
        end
    end
    $display("frame %0dx%0d slice %0dx%0d legal=%0d", pw, ph, sw, sh, legal);

    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    pic_w = DIM_W'(pw); pic_h = DIM_W'(ph); slice_w = DIM_W'(sw); slice_h = DIM_W'(sh);
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs: the DUT must work from its latched copy.
    pic_w = DIM_W'($urandom); pic_h = DIM_W'($urandom);
    slice_w = DIM_W'($urandom); slice_h = DIM_W'($urandom);

    if (!legal) begin
      for (k = 1; k <= err_cycle + 1; k++) begin
        chk("err_busy", busy, (k <= err_cycle));
        chk("err_pulse", cfg_err, (k == err_cycle));
        chk("err_valid", cmd_valid, 0);
        chk("err_fdone", frame_done, 0);
        cmd_ready  = ($urandom_range(1) == 1);
        slice_done = ($urandom_range(1) == 1);
        if (k <= err_cycle) @(negedge clk);
      end
      cmd_ready = 1'b0; slice_done = 1'b0;
      return;
    end

    outstanding = 0; draining = 0; finished = 0; k = 1;
    while (!finished && k < 3000) begin
      in_issue  = (k >= issue_cycle) && !draining;
      exp_valid = in_issue && (outstanding < MAX_OUT);
      exp_fd    = draining && (outstanding == 0);
      chk("busy", busy, 1);
      chk("valid", cmd_valid, exp_valid);
      chk("frame_done", frame_done, exp_fd);
      chk("cfg_err", cfg_err, 0);
      if (exp_valid) begin
        chk("cmd_x", cmd_x, qx[0]);
        chk("cmd_y", cmd_y, qy[0]);
        chk("cmd_idx", cmd_idx, qi[0]);
        chk("cmd_last", cmd_last, (qx.size() == 1));
      end
      if (abort_drain && draining) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_drain");
        start = 1'b0; cmd_ready = 1'b0; slice_done = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk_all_zero("rst_hold");
        end
        slice_done = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk_all_zero("post_rst");
        end
        return;
      end

      rdy = ($urandom_range(99) < ready_pct);
      if (done_pct < 0) begin
        sd = (sched.size() > 0) && (sched[0] == k);
        if (sd) void'(sched.pop_front());
      end else begin
        sd = ((withhold == 0) || (k >= issue_cycle + withhold)) && ($urandom_range(99) < done_pct);
      end
      hs = exp_valid && rdy;
      if (hs) begin
        if (done_pct < 0) sched.push_back(k + 3);
        $display("cmd idx=%0d x=%0d y=%0d last=%0d cycle=%0d", qi[0], qx[0], qy[0], qx.size() == 1, k);
        if (qx.size() == 1) draining = 1;
        void'(qx.pop_front()); void'(qy.pop_front()); void'(qi.pop_front());
      end
      outstanding = outstanding + (hs ? 1 : 0) - ((sd && outstanding > 0) ? 1 : 0);
      if (exp_fd) finished = 1;
      cmd_ready  = rdy;
      slice_done = sd;
      start      = ($urandom_range(9) == 0);
      @(negedge clk);
      k++;
    end
    start = 1'b0; cmd_ready = 1'b0; slice_done = 1'b0;
    chk("frame_finished", finished, 1);
    chk("after_busy", busy, 0);
    chk("after_fdone", frame_done, 0);
    chk("cmds_left", qx.size(), 0);
  endtask

  initial begin
    int pw, ph, sw, sh, sel;
    rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b0; slice_done = 1'b0;
    pic_w = '0; pic_h = '0; slice_w = '0; slice_h = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame(64, 32, 32, 16, 100, -1, 0, 0);   // first valid on cycle 5, 4 commands
    run_frame(100, 32, 32, 16, 50, 50, 0, 0);   // width does not tile
    run_frame(64, 32, 0, 16, 50, 50, 0, 0);     // zero slice width
    run_frame(64, 48, 32, 20, 50, 50, 0, 0);    // height does not tile
    run_frame(64, 32, 32, 16, 100, 60, 20, 0);  // completions withheld: cap at MAX_OUT
    run_frame(96, 48, 32, 16, 15, 40, 0, 0);    // long cmd_ready stalls
    run_frame(64, 32, 32, 16, 100, 30, 0, 1);   // reset while draining
    run_frame(64, 32, 32, 16, 100, -1, 0, 0);   // clean frame after reset

    for (int n = 0; n < 30; n++) begin
      sw = $urandom_range(1, 20); sh = $urandom_range(1, 20);
      pw = sw * $urandom_range(1, 4); ph = sh * $urandom_range(1, 4);
      sel = $urandom_range(0, 9);
      if (sel == 0 && sw > 1) pw = pw + $urandom_range(1, sw - 1);
      if (sel == 1) sh = 0;
      if (sel == 2 && sh > 1) ph = ph + $urandom_range(1, sh - 1);
      run_frame(pw, ph, sw, sh, $urandom_range(20, 100), $urandom_range(20, 80),
                $urandom_range(0, 1) * 8, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
